// File: rtl/hinf_frame_streamer.sv
// hinf_frame_streamer
// Serial-to-frame / frame-to-serial front end for the H-infinity filter core.
// The input path collects NUM_CH samples from an RX FIFO into one parallel
// frame; the output path serialises a result frame into a TX FIFO. The two
// paths share no state, so loading frame k+1 overlaps serialising result k.
//
// Optional build macro OUT_SAT_EN: when defined, result elements are
// saturated from signed RES_W to signed DATA_W; otherwise the low DATA_W
// bits are kept.
//
// Input FSM
//   state | meaning
//   IDLE  | waiting for Start
//   LOAD  | popping NUM_CH samples from the RX FIFO (stalls on Rx_Empty)
//   HOLD  | frame presented on frm_data until frm_ready
// Output FSM
//   state | meaning
//   OIDLE | result buffer free, res_ready high
//   SEND  | writing out_buf elements to the TX FIFO (stalls on Tx_Full)
//
// D_Rd, D_Wr and res_ready are forced low while rst is high so that no FIFO
// word or result frame is consumed by a cycle that reset then discards.
module hinf_frame_streamer #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 64,
    parameter int RES_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Start,
    input  logic                     Rx_Empty,
    input  logic [DATA_W-1:0]        Xin,
    output logic                     D_Rd,
    output logic                     frm_valid,
    output logic [NUM_CH*DATA_W-1:0] frm_data,
    input  logic                     frm_ready,
    input  logic                     res_valid,
    input  logic [NUM_CH*RES_W-1:0]  res_data,
    output logic                     res_ready,
    input  logic                     Tx_Full,
    output logic                     D_Wr,
    output logic [DATA_W-1:0]        D_out,
    output logic                     Done,
    output logic                     busy
);
    localparam int            CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} in_state_t;
    typedef enum logic       {OIDLE, SEND}      out_state_t;

    in_state_t         in_state_q, in_state_d;
    out_state_t        out_state_q, out_state_d;
    logic [CW-1:0]     wr_idx_q, wr_idx_d;
    logic [CW-1:0]     rd_idx_q, rd_idx_d;
    logic              done_q, done_d;
    logic              res_take;
    logic [DATA_W-1:0] in_buf_q  [NUM_CH];
    logic [DATA_W-1:0] out_buf_q [NUM_CH];
    logic [DATA_W-1:0] res_conv  [NUM_CH];

`ifdef OUT_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    // Per-element result narrowing and input frame packing.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_elem
        assign frm_data[g*DATA_W +: DATA_W] = in_buf_q[g];
`ifdef OUT_SAT_EN
        // In range exactly when every bit from the DATA_W sign position up agrees.
        logic [RES_W-DATA_W:0] top;
        assign top = res_data[g*RES_W+DATA_W-1 +: RES_W-DATA_W+1];
        assign res_conv[g] = ((&top) || !(|top)) ? res_data[g*RES_W +: DATA_W]
                                                 : (top[RES_W-DATA_W] ? SAT_MIN : SAT_MAX);
`else
        assign res_conv[g] = res_data[g*RES_W +: DATA_W];
        if (RES_W > DATA_W) begin : g_drop
            logic unused_hi;
            assign unused_hi = ^res_data[g*RES_W+DATA_W +: RES_W-DATA_W];
        end
`endif
    end

    // Input FSM: next state, RX pop and write index.
    always_comb begin
        in_state_d = in_state_q;
        wr_idx_d   = wr_idx_q;
        D_Rd       = 1'b0;
        case (in_state_q)
            IDLE: if (Start) in_state_d = LOAD;
            LOAD: begin
                D_Rd = !Rx_Empty && !rst;
                if (D_Rd) begin
                    if (wr_idx_q == LAST) begin
                        wr_idx_d   = '0;
                        in_state_d = HOLD;
                    end else begin
                        wr_idx_d = wr_idx_q + CW'(1);
                    end
                end
            end
            HOLD: if (frm_ready) in_state_d = IDLE;
            default: in_state_d = IDLE;
        endcase
    end

    // Output FSM: next state, result capture, TX push and end-of-frame pulse.
    always_comb begin
        out_state_d = out_state_q;
        rd_idx_d    = rd_idx_q;
        res_ready   = 1'b0;
        res_take    = 1'b0;
        D_Wr        = 1'b0;
        done_d      = 1'b0;
        case (out_state_q)
            OIDLE: begin
                res_ready = !rst;
                res_take  = res_valid && res_ready;
                if (res_take) out_state_d = SEND;
            end
            SEND: begin
                D_Wr = !Tx_Full && !rst;
                if (D_Wr) begin
                    if (rd_idx_q == LAST) begin
                        rd_idx_d    = '0;
                        out_state_d = OIDLE;
                        done_d      = 1'b1;
                    end else begin
                        rd_idx_d = rd_idx_q + CW'(1);
                    end
                end
            end
            default: out_state_d = OIDLE;
        endcase
    end

    // State, index and Done registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state_q  <= IDLE;
            out_state_q <= OIDLE;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            done_q      <= done_d;
        end
    end

    // Frame buffers: samples land one per pop, results are captured whole.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                in_buf_q[i]  <= '0;
                out_buf_q[i] <= '0;
            end
        end else begin
            if (D_Rd) in_buf_q[wr_idx_q] <= Xin;
            if (res_take) begin
                for (int i = 0; i < NUM_CH; i++) out_buf_q[i] <= res_conv[i];
            end
        end
    end

    assign frm_valid = (in_state_q == HOLD);
    assign D_out     = out_buf_q[rd_idx_q];
    assign Done      = done_q;
    assign busy      = (in_state_q != IDLE) || (out_state_q != OIDLE);

endmodule

// File: doc/hinf_frame_streamer.md
Name: hinf_frame_streamer

Overview:
- Parametrised serial-to-frame / frame-to-serial front end for the H-infinity filter core.
- Input side: reads NUM_CH samples of DATA_W bits, one per clock, from an RX FIFO, then presents them to the core as one parallel frame.
- Output side: accepts the core's parallel result frame and writes it element by element to a TX FIFO, pulsing Done at the end.
- Input and output paths run independently, so loading frame k+1 overlaps serialising result k.

Parameters:
- NUM_CH, 8, samples per frame (2..64).
- DATA_W, 64, signed input sample width and D_out width.
- RES_W, 64, signed per-element width of the core result (RES_W >= DATA_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  begin loading one frame; sampled only in input state IDLE.
- Rx_Empty  in  1  RX FIFO empty.
- Xin  in  DATA_W  RX FIFO head word (first-word-fall-through), signed.
- D_Rd  out  1  RX FIFO pop; Xin is consumed on the same edge.
- frm_valid  out  1  parallel input frame valid.
- frm_data  out  NUM_CH*DATA_W  frame; element 0 at bits [DATA_W-1:0].
- frm_ready  in  1  core accepts frame.
- res_valid  in  1  core result frame valid.
- res_data  in  NUM_CH*RES_W  result; element 0 at LSBs.
- res_ready  out  1  result buffer free.
- Tx_Full  in  1  TX FIFO full.
- D_Wr  out  1  TX FIFO push.
- D_out  out  DATA_W  TX word, signed.
- Done  out  1  one-cycle pulse after the last element of a frame is written.
- busy  out  1  either FSM not idle.

Behaviour:
- Reset values: all outputs 0, both FSMs idle, counters 0, buffers cleared. Reset mid-operation discards any partial input frame and any pending output; no Done is issued for it.
- Input FSM states: IDLE, LOAD, HOLD.
  - IDLE: go to LOAD when Start=1. Start in any other state is ignored.
  - LOAD: D_Rd = !Rx_Empty (combinational). On each D_Rd cycle, write Xin to in_buf[wr_idx] and increment wr_idx. Rx_Empty stalls the load with no timeout. After the NUM_CH-th read, clear wr_idx and go to HOLD.
  - HOLD: frm_valid=1 and frm_data=in_buf, both stable until frm_valid&&frm_ready. On that handshake go to IDLE.
  - Minimum Start-to-frm_valid latency is NUM_CH+1 cycles.
- Output FSM states: OIDLE, SEND.
  - OIDLE: res_ready=1. On res_valid&&res_ready, capture res_data into out_buf and go to SEND.
  - SEND: res_ready=0. D_Wr = !Tx_Full (combinational). D_out = conv(out_buf[rd_idx]). rd_idx increments on each D_Wr cycle. When Tx_Full=1, D_Wr=0 and D_out holds its value.
  - After the NUM_CH-th write: Done=1 for the next cycle only, clear rd_idx, return to OIDLE.
  - First write occurs 1 cycle after result capture.
- conv() narrows RES_W to DATA_W: keep the low DATA_W bits (truncate) unless OUT_SAT_EN is defined. When RES_W==DATA_W it is identity.
- Both FSMs may handshake in the same cycle; they share no state.
- Counter width is clog2(NUM_CH). Counters wrap to 0 exactly at NUM_CH and never index past NUM_CH-1.
- busy = (in_state!=IDLE) || (out_state!=OIDLE).

Optional Feature:
- Macro OUT_SAT_EN.
- Defined: conv() saturates signed RES_W to signed DATA_W. Values above 2^(DATA_W-1)-1 clamp to that value; values below -2^(DATA_W-1) clamp to that value.
- Not defined: conv() is plain truncation to the low DATA_W bits; the saturation compare logic is not synthesised.

Test Plan:
- Basic frame (NUM_CH=8, DATA_W=64): Start 1 cycle, Rx_Empty=0, Xin=1..8. Required: D_Rd high for exactly 8 cycles; frm_valid rises on cycle 9 with element0=1 and element7=8. Loop the frame back as the result with Tx_Full=0: D_out sequence 1..8, then Done one cycle after the 8th D_Wr.
- RX stall: Rx_Empty=1 for 5 cycles after sample 3. Required: D_Rd=0 during the stall and the frame content is still 1..8 in order.
- TX backpressure: Tx_Full=1 while rd_idx=4 for 3 cycles. Required: D_Wr=0 and D_out=5 held throughout; total of exactly 8 writes; Done fires once.
- Overlap: issue Start for frame B (Xin=11..18) while frame A is in SEND. Required: A's D_out stays 1..8 uncorrupted; B's frm_valid asserts independently; a Start arriving in HOLD is ignored.
- Reset mid-LOAD after 4 reads: assert rst 1 cycle. Required: all outputs 0 and frm_valid never asserts for the partial frame. A new Start loads a clean 8 samples.
- OUT_SAT_EN with RES_W=72: results 2^70, -2^70 and 5. Required: D_out = 0x7FFF_FFFF_FFFF_FFFF, 0x8000_0000_0000_0000, 5. With the macro undefined, D_out = 0, 0, 5 (truncation).
